// File: rtl/mac_digit_serial_if.sv
// Operand/result bus of the digit-serial MAC: start handshake in, result and status out.
interface mac_digit_serial_if #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12
);
    logic                   start_i;
    logic [WIDTH-1:0]       a_i;
    logic [WIDTH-1:0]       b_i;
    logic                   acc_en_i;
    logic                   clr_i;
    logic                   busy_o;
    logic                   done_o;
    logic [2*WIDTH-1:0]     product_o;
    logic [ACC_WIDTH-1:0]   acc_o;
    logic                   ovf_o;

    modport master (
        output start_i, a_i, b_i, acc_en_i, clr_i,
        input  busy_o, done_o, product_o, acc_o, ovf_o
    );

    modport slave (
        input  start_i, a_i, b_i, acc_en_i, clr_i,
        output busy_o, done_o, product_o, acc_o, ovf_o
    );
endinterface

// File: rtl/mac_digit_serial.sv
// Unsigned digit-serial multiply-accumulate: one 2x2-bit partial product per cycle,
// then the finished product is loaded into or added onto a wide accumulator.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; clr honoured here only
// MULT   | one partial product per edge, D*D edges in total
// ACC    | single edge: load/add product into acc, raise done
module mac_digit_serial #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    mac_digit_serial_if.slave bus
);
    localparam int D   = WIDTH / 2;
    localparam int NPP = D * D;
    localparam int CW  = (NPP > 1) ? $clog2(NPP) : 1;
    localparam int PW  = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 acc_en_q;
    logic [PW-1:0]        product_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    logic                 done_q;

    logic [CW-1:0]        dig_i, dig_j;
    logic [CW:0]          sum_ij;
    logic [CW+1:0]        shamt;
    logic [1:0]           a_dig, b_dig;
    logic [3:0]           pp;
    logic [PW-1:0]        pp_sh;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 last_pp;

    // Select the current digit pair, form its partial product and the accumulator sum.
    always_comb begin
        dig_i   = cnt_q / CW'(D);
        dig_j   = cnt_q % CW'(D);
        a_dig   = 2'(a_q >> {dig_i, 1'b0});
        b_dig   = 2'(b_q >> {dig_j, 1'b0});
        pp      = {2'b00, a_dig} * {2'b00, b_dig};
        sum_ij  = {1'b0, dig_i} + {1'b0, dig_j};
        shamt   = {sum_ij, 1'b0};
        pp_sh   = PW'(pp) << shamt;
        acc_sum = {1'b0, acc_q} + (ACC_WIDTH + 1)'(product_q);
        last_pp = (cnt_q == CW'(NPP - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_MULT;
            S_MULT:  if (last_pp)     state_d = S_ACC;
            S_ACC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        bus.busy_o = (state_q != S_IDLE);
    end

    // Datapath: operand capture, shift-add of partial products, accumulate and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_en_q  <= 1'b0;
            product_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // clr is applied first so a same-edge start accumulates onto zero
                    if (bus.clr_i) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                    if (bus.start_i) begin
                        a_q       <= bus.a_i;
                        b_q       <= bus.b_i;
                        acc_en_q  <= bus.acc_en_i;
                        product_q <= '0;
                        cnt_q     <= '0;
                    end
                end
                S_MULT: begin
                    product_q <= product_q + pp_sh;
                    cnt_q     <= cnt_q + CW'(1);
                end
                S_ACC: begin
                    if (acc_en_q) begin
                        acc_q <= acc_sum[ACC_WIDTH-1:0];
                        ovf_q <= ovf_q | acc_sum[ACC_WIDTH];
                    end else begin
                        acc_q <= ACC_WIDTH'(product_q);
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done_o    = done_q;
    assign bus.product_o = product_q;
    assign bus.acc_o     = acc_q;
    assign bus.ovf_o     = ovf_q;
endmodule

// File: tb/tb_mac_digit_serial.sv
// Three MAC instances (4/12, 4/8, 8/20) share one stimulus stream. A transaction-level
// model (product = a*b after D*D+1 busy cycles) checks every instance each cycle;
// directed sequences add hand-computed constants for the listed corner cases.
module tb_mac_digit_serial;
    localparam int W0 = 4, A0 = 12;
    localparam int W1 = 4, A1 = 8;
    localparam int W2 = 8, A2 = 20;

    logic       clk;
    logic       rst;
    logic       start, acc_en, clr;
    logic [7:0] a, b;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    mac_digit_serial_if #(.WIDTH(W0), .ACC_WIDTH(A0)) if0 ();
    mac_digit_serial_if #(.WIDTH(W1), .ACC_WIDTH(A1)) if1 ();
    mac_digit_serial_if #(.WIDTH(W2), .ACC_WIDTH(A2)) if2 ();

    assign if0.start_i = start; assign if0.acc_en_i = acc_en; assign if0.clr_i = clr;
    assign if1.start_i = start; assign if1.acc_en_i = acc_en; assign if1.clr_i = clr;
    assign if2.start_i = start; assign if2.acc_en_i = acc_en; assign if2.clr_i = clr;
    assign if0.a_i = a[W0-1:0]; assign if0.b_i = b[W0-1:0];
    assign if1.a_i = a[W1-1:0]; assign if1.b_i = b[W1-1:0];
    assign if2.a_i = a[W2-1:0]; assign if2.b_i = b[W2-1:0];

    mac_digit_serial #(.WIDTH(W0), .ACC_WIDTH(A0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    mac_digit_serial #(.WIDTH(W1), .ACC_WIDTH(A1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    mac_digit_serial #(.WIDTH(W2), .ACC_WIDTH(A2)) u2 (.clk(clk), .rst(rst), .bus(if2));

    logic [63:0] o_prod[3], o_acc[3];
    logic        o_busy[3], o_done[3], o_ovf[3];
    assign o_prod[0] = 64'(if0.product_o); assign o_acc[0] = 64'(if0.acc_o);
    assign o_prod[1] = 64'(if1.product_o); assign o_acc[1] = 64'(if1.acc_o);
    assign o_prod[2] = 64'(if2.product_o); assign o_acc[2] = 64'(if2.acc_o);
    assign o_busy[0] = if0.busy_o; assign o_done[0] = if0.done_o; assign o_ovf[0] = if0.ovf_o;
    assign o_busy[1] = if1.busy_o; assign o_done[1] = if1.done_o; assign o_ovf[1] = if1.ovf_o;
    assign o_busy[2] = if2.busy_o; assign o_done[2] = if2.done_o; assign o_ovf[2] = if2.ovf_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          kw[3]   = '{W0, W1, W2};
    int          kacc[3] = '{A0, A1, A2};
    int          m_rem[3];
    logic [63:0] m_prod[3], m_acc[3], m_a[3], m_b[3];
    logic        m_en[3], m_ovf[3], m_done[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [63:0] amask, accmask, prod, sum;
            int          ncyc;
            amask   = (64'd1 << kw[k]) - 64'd1;
            accmask = (64'd1 << kacc[k]) - 64'd1;
            ncyc    = (kw[k] / 2) * (kw[k] / 2) + 1;
            if (rst) begin
                m_rem[k] <= 0; m_prod[k] <= '0; m_acc[k] <= '0;
                m_a[k] <= '0; m_b[k] <= '0; m_en[k] <= 1'b0;
                m_ovf[k] <= 1'b0; m_done[k] <= 1'b0;
            end else begin
                m_done[k] <= 1'b0;
                if (m_rem[k] == 0) begin
                    if (clr) begin
                        m_acc[k] <= '0;
                        m_ovf[k] <= 1'b0;
                    end
                    if (start) begin
                        m_a[k]    <= 64'(a) & amask;
                        m_b[k]    <= 64'(b) & amask;
                        m_en[k]   <= acc_en;
                        m_prod[k] <= '0;
                        m_rem[k]  <= ncyc;
                    end
                end else begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) begin
                        prod = m_a[k] * m_b[k];
                        m_prod[k] <= prod;
                        if (m_en[k]) begin
                            sum = m_acc[k] + prod;
                            m_acc[k] <= sum & accmask;
                            if ((sum >> kacc[k]) != 0) m_ovf[k] <= 1'b1;
                        end else begin
                            m_acc[k] <= prod;
                        end
                        m_done[k] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("m%0d busy", k), 64'(o_busy[k]), 64'(m_rem[k] != 0));
                check($sformatf("m%0d done", k), 64'(o_done[k]), 64'(m_done[k]));
                check($sformatf("m%0d acc", k), o_acc[k], m_acc[k]);
                check($sformatf("m%0d ovf", k), 64'(o_ovf[k]), 64'(m_ovf[k]));
                if (m_rem[k] == 0)
                    check($sformatf("m%0d product", k), o_prod[k], m_prod[k]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                            input logic en, input logic cl);
        a = av; b = bv; acc_en = en; clr = cl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic wait_done(input int k, input int exp_lat, input string nm);
        int n = 0;
        bit got = 0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            if (o_done[k]) got = 1;
        end
        check({nm, " latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic wait_idle_all();
        int n = 0;
        while (n < 40 && (o_busy[0] || o_busy[1] || o_busy[2])) begin
            @(posedge clk); #1;
            n++;
        end
        check("all idle", 64'(o_busy[0] || o_busy[1] || o_busy[2]), 64'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        en;
        logic [63:0] exp_prod;
        logic [63:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int dcount;

        tbl[0] = '{a: 8'd13, b: 8'd11, en: 1'b0, exp_prod: 64'd143, exp_acc: 64'd143, exp_ovf: 1'b0};
        tbl[1] = '{a: 8'd15, b: 8'd15, en: 1'b1, exp_prod: 64'd225, exp_acc: 64'd368, exp_ovf: 1'b0};
        tbl[2] = '{a: 8'd0,  b: 8'd7,  en: 1'b1, exp_prod: 64'd0,   exp_acc: 64'd368, exp_ovf: 1'b0};
        tbl[3] = '{a: 8'd3,  b: 8'd2,  en: 1'b0, exp_prod: 64'd6,   exp_acc: 64'd6,   exp_ovf: 1'b0};
        tbl[4] = '{a: 8'd15, b: 8'd14, en: 1'b1, exp_prod: 64'd210, exp_acc: 64'd216, exp_ovf: 1'b0};

        rst = 1'b1; start = 1'b0; acc_en = 1'b0; clr = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;

        // reset state
        check("rst busy",    64'(o_busy[0]), 64'd0);
        check("rst done",    64'(o_done[0]), 64'd0);
        check("rst product", o_prod[0], 64'd0);
        check("rst acc",     o_acc[0], 64'd0);
        check("rst ovf",     64'(o_ovf[0]), 64'd0);

        // back-to-back table on the 4/12 instance, each start issued in the done cycle
        for (int i = 0; i < 5; i++) begin
            start_op(tbl[i].a, tbl[i].b, tbl[i].en, 1'b0);
            wait_done(0, 5, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d product", i), o_prod[0], tbl[i].exp_prod);
            check($sformatf("tbl%0d acc", i), o_acc[0], tbl[i].exp_acc);
            check($sformatf("tbl%0d ovf", i), 64'(o_ovf[0]), 64'(tbl[i].exp_ovf));
        end

        // overflow and clear on the 8-bit accumulator
        wait_idle_all();
        do_clr();
        check("clr1 acc", o_acc[1], 64'd0);
        check("clr1 ovf", 64'(o_ovf[1]), 64'd0);
        start_op(8'd15, 8'd15, 1'b1, 1'b0);
        wait_done(1, 5, "ovf op1");
        check("ovf op1 acc", o_acc[1], 64'd225);
        check("ovf op1 ovf", 64'(o_ovf[1]), 64'd0);
        wait_idle_all();
        start_op(8'd15, 8'd15, 1'b1, 1'b0);
        wait_done(1, 5, "ovf op2");
        check("ovf op2 acc", o_acc[1], 64'd194);
        check("ovf op2 ovf", 64'(o_ovf[1]), 64'd1);
        wait_idle_all();
        do_clr();
        check("clr2 acc", o_acc[1], 64'd0);
        check("clr2 ovf", 64'(o_ovf[1]), 64'd0);
        start_op(8'd3, 8'd2, 1'b1, 1'b1);
        wait_done(1, 5, "clr+start");
        check("clr+start acc", o_acc[1], 64'd6);
        check("clr+start ovf", 64'(o_ovf[1]), 64'd0);

        // start and clr while busy are ignored
        wait_idle_all();
        start_op(8'd9, 8'd7, 1'b0, 1'b0);
        a = 8'd1; b = 8'd1; acc_en = 1'b1; clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        wait_done(0, 4, "busy ignore");
        check("busy ignore product", o_prod[0], 64'd63);
        check("busy ignore acc", o_acc[0], 64'd63);

        // reset on the 2nd MULT edge aborts the operation
        wait_idle_all();
        start_op(8'd5, 8'd5, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(o_busy[0]), 64'd0);
        check("abort product", o_prod[0], 64'd0);
        check("abort acc", o_acc[0], 64'd0);
        check("abort ovf", 64'(o_ovf[0]), 64'd0);
        dcount = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_done[0]) dcount++;
        end
        check("abort no done", 64'(dcount), 64'd0);
        start_op(8'd6, 8'd7, 1'b1, 1'b0);
        wait_done(0, 5, "after abort");
        check("after abort product", o_prod[0], 64'd42);
        check("after abort acc", o_acc[0], 64'd42);

        // width scaling on the 8/20 instance
        wait_idle_all();
        start_op(8'd255, 8'd255, 1'b0, 1'b0);
        wait_done(2, 17, "w8 max");
        check("w8 max product", o_prod[2], 64'd65025);
        check("w8 max acc", o_acc[2], 64'd65025);
        wait_idle_all();
        start_op(8'd1, 8'd0, 1'b1, 1'b0);
        wait_done(2, 17, "w8 zero");
        check("w8 zero product", o_prod[2], 64'd0);
        check("w8 zero acc", o_acc[2], 64'd65025);
        check("w8 zero ovf", 64'(o_ovf[2]), 64'd0);

        // randomized traffic against the model
        wait_idle_all();
        for (int c = 0; c < 3000; c++) begin
            a      = 8'($urandom);
            b      = 8'($urandom);
            acc_en = 1'($urandom_range(0, 1));
            clr    = ($urandom_range(0, 7) == 0);
            start  = ($urandom_range(0, 2) == 0);
            rst    = ($urandom_range(0, 249) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0; clr = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
